// File: rtl/boot_copier_pkg.sv
// Shared constants for the boot image copier: state codes, byte-lane mask,
// default image bases and the word address helper.
package boot_copier_pkg;

  localparam int unsigned TEXT_BITS = 32;
  localparam logic [TEXT_BITS-1:0] DEFAULT_SRC_BASE = 32'h0000_0000;
  localparam logic [TEXT_BITS-1:0] DEFAULT_DST_BASE = 32'h0000_0000;

  localparam logic [3:0] PM_BYTE_ALL = 4'b1111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  // Byte address of word idx; wraps silently at 2^32.
  function automatic logic [TEXT_BITS-1:0] word_addr(input logic [TEXT_BITS-1:0] base,
                                                     input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/boot_copier_wait_timer.sv
// Per-word flash wait counter; expired flags the last permitted wait cycle.
module boot_copier_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/boot_copier.sv
// Boot-time image loader: copies WORDS flash words into program memory while
// holding the CPU off the bus, with running checksum and sticky timeout error.
module boot_copier
  import boot_copier_pkg::*;
#(
  parameter logic [31:0] SRC_BASE       = DEFAULT_SRC_BASE,
  parameter logic [31:0] DST_BASE       = DEFAULT_DST_BASE,
  parameter int unsigned WORDS          = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_flash_ren,
  output logic [31:0] o_flash_addr,
  input  logic [31:0] i_flash_data,
  input  logic        i_flash_ready,
  output logic        o_pm_wen,
  output logic [31:0] o_pm_addr,
  output logic [31:0] o_pm_data,
  output logic [3:0]  o_pm_byte_select,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_words_copied,
  output logic [31:0] o_checksum
);

  // state | meaning
  // IDLE  | no copy pending, bus released
  // REQ   | issue flash read for current index
  // WAIT  | wait for flash_ready, timeout armed
  // WRITE | write latched word, advance index
  // DONE  | image complete, CPU released
  // ERR   | flash timeout, CPU kept on hold

  localparam logic [15:0] LAST_INDEX = 16'(WORDS - 1);

  logic [2:0]  r_state;
  logic [15:0] r_index;
  logic        r_flash_ren;
  logic [31:0] r_flash_addr;
  logic        r_pm_wen;
  logic [31:0] r_pm_addr;
  logic [31:0] r_pm_data;
  logic        r_cpu_hold;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words_copied;
  logic [31:0] r_checksum;

  logic w_timer_clear;
  logic w_timer_enable;
  logic w_timer_expired;

  assign w_timer_clear  = (r_state == ST_REQ);
  assign w_timer_enable = (r_state == ST_WAIT) && !i_flash_ready;

  boot_copier_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_enable),
    .o_expired(w_timer_expired)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= AUTO_START ? ST_REQ : ST_IDLE;
      r_index        <= '0;
      r_flash_ren    <= 1'b0;
      r_flash_addr   <= '0;
      r_pm_wen       <= 1'b0;
      r_pm_addr      <= '0;
      r_pm_data      <= '0;
      r_cpu_hold     <= AUTO_START;
      r_busy         <= AUTO_START;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_copied <= '0;
      r_checksum     <= '0;
    end else begin
      r_flash_ren <= 1'b0;
      r_pm_wen    <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_start) begin
            r_index        <= '0;
            r_words_copied <= '0;
            r_checksum     <= '0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_busy         <= 1'b1;
            r_cpu_hold     <= 1'b1;
            r_state        <= ST_REQ;
          end else if (r_state == ST_DONE) begin
            // Released one cycle after the final write strobe.
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_cpu_hold <= 1'b0;
          end
        end
        ST_REQ: begin
          r_flash_ren  <= 1'b1;
          r_flash_addr <= word_addr(SRC_BASE, r_index);
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_flash_ready) begin
            r_pm_data <= i_flash_data;
            r_state   <= ST_WRITE;
          end else if (w_timer_expired) begin
            // cpu_hold stays high so a partial image never runs.
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_ERR;
          end
        end
        ST_WRITE: begin
          r_pm_wen       <= 1'b1;
          r_pm_addr      <= word_addr(DST_BASE, r_index);
          r_checksum     <= r_checksum + r_pm_data;
          r_words_copied <= r_words_copied + 16'd1;
          if (r_index == LAST_INDEX) begin
            r_state <= ST_DONE;
          end else begin
            r_index <= r_index + 16'd1;
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_flash_ren      = r_flash_ren;
  assign o_flash_addr     = r_flash_addr;
  assign o_pm_wen         = r_pm_wen;
  assign o_pm_addr        = r_pm_addr;
  assign o_pm_data        = r_pm_data;
  assign o_pm_byte_select = PM_BYTE_ALL;
  assign o_cpu_hold       = r_cpu_hold;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_words_copied   = r_words_copied;
  assign o_checksum       = r_checksum;

endmodule

// File: doc/boot_copier.md
# boot_copier

Boot-time image loader between the SPI flash controller and program memory. After reset or on command, copies `WORDS` 32-bit words from flash at `SRC_BASE` into program memory at `DST_BASE`, holding the CPU off the bus until the image is complete. Reports a running checksum, a word count, and a sticky timeout error. Sits in the SoC top beside the bus and drives the flash and program-memory ports while `cpu_hold` is high.

## Interface
- `SRC_BASE`, default 32'h0000_0000: flash byte address of word 0.
- `DST_BASE`, default 32'h0000_0000: program-memory byte address of word 0.
- `WORDS`, default 1024: words to copy; legal range 1..65535.
- `TIMEOUT_CYCLES`, default 4096: maximum wait for `flash_ready` per word.
- `AUTO_START`, default 1: when 1, a copy starts automatically after reset.

Ports:
- `clk` in 1: CPU clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to begin a copy.
- `flash_ren` out 1: one-cycle flash read strobe.
- `flash_addr` out 32: flash byte address.
- `flash_data` in 32: flash read data.
- `flash_ready` in 1: `flash_data` is valid this cycle.
- `pm_wen` out 1: one-cycle program-memory write strobe.
- `pm_addr` out 32: program-memory byte address.
- `pm_data` out 32: word to write.
- `pm_byte_select` out 4: constant 4'b1111.
- `cpu_hold` out 1: CPU held in reset / off the bus.
- `busy` out 1: copy in progress.
- `done` out 1: copy completed.
- `error` out 1: flash timeout occurred (sticky).
- `words_copied` out 16: number of completed writes.
- `checksum` out 32: wrapping sum of copied words.

## Operation
- States: IDLE, REQ, WAIT, WRITE, DONE, ERR.
- Reset values:
  - State: REQ if `AUTO_START`=1, else IDLE.
  - `cpu_hold` = `AUTO_START`; `busy` = `AUTO_START`.
  - All other outputs are 0, except `pm_byte_select` = 4'b1111.
  - Index, wait counter and `checksum` are 0.
- IDLE / DONE / ERR + `start`: clear index, `words_copied`, `checksum`, `done`, `error`; set `busy` and `cpu_hold`; go to REQ.
- REQ: assert `flash_ren` for one cycle with `flash_addr = SRC_BASE + 4*index`; clear the wait counter; go to WAIT.
- WAIT:
  - If `flash_ready`: latch `flash_data` into `pm_data`; go to WRITE.
  - Else, if the wait counter equals `TIMEOUT_CYCLES-1`: go to ERR.
  - Otherwise increment the wait counter.
- WRITE:
  - Assert `pm_wen` with `pm_addr = DST_BASE + 4*index`.
  - Update `checksum += pm_data` (mod 2^32) and `words_copied += 1`.
  - If `index == WORDS-1`: go to DONE. Otherwise `index += 1` and go to REQ.
- DONE: `done`=1, `busy`=0, `cpu_hold`=0.
- ERR: `error`=1, `busy`=0, `cpu_hold` stays 1 so a partial image never runs.
- `start` while `busy` is ignored.
- `flash_ready` outside WAIT is ignored.
- Address arithmetic is 32-bit and wraps silently.
- Reset mid-copy aborts immediately with no further strobes. With `AUTO_START`=1 the copy restarts from word 0.
- `start` and `flash_ready` in the same cycle: only the one legal for the current state acts.

## Timing
- Strobes are registered outputs, high exactly one cycle.
- `flash_ren` is at least 1 cycle after entry to REQ.
- `flash_ready` is sampled no earlier than the cycle after `flash_ren`.
- Per-word cost: 1 (REQ) + L (WAIT cycles up to and including `flash_ready`) + 1 (WRITE). With L=1, each word takes 3 cycles.
- `pm_addr`, `pm_data` and `pm_wen` are valid in the same cycle.
- `done` and `cpu_hold` deassertion happen in the cycle after the last `pm_wen`.
- Timeout: ERR is entered `TIMEOUT_CYCLES` cycles after entering WAIT without `flash_ready`.
- `start` → first `flash_ren`: 2 cycles (IDLE→REQ, REQ drives the strobe).

## Structure
- Shared package / `config.vh`:
  - State encoding localparams.
  - `PM_BYTE_ALL` = 4'b1111.
  - Default `SRC_BASE` / `DST_BASE` values as defines next to `TEXT_BITS`.
- One sub-module, `wait_timer`: clear/enable counter with an `expired` output at `TIMEOUT_CYCLES-1`, parameterised width from `$clog2(TIMEOUT_CYCLES)`.
- FSM, index, checksum and address generation live in the top of the block.

## Test plan
- `AUTO_START`=1, `WORDS`=4, flash model returns `0x11111111*(i+1)` with L=1:
  - Expect 4 `pm_wen` at `pm_addr` 0,4,8,12.
  - `checksum`=0xAAAAAAAA, `words_copied`=4, `done`=1, `cpu_hold`=0 at cycle 13 after reset release.
- `SRC_BASE`=0x10000, `DST_BASE`=0x400, L=5: `flash_addr` sequence 0x10000, 0x10004…; per-word spacing 7 cycles; `pm_addr` starts at 0x400.
- Flash never asserts `flash_ready` on word 2, `TIMEOUT_CYCLES`=16:
  - ERR after exactly 16 WAIT cycles; `error`=1, `cpu_hold`=1, `words_copied`=2.
  - Then `start` → recopy from word 0 succeeds.
- `AUTO_START`=0: no strobes after reset. `start` pulses during the copy are ignored (write count stays `WORDS`). `flash_ready` glitch while in REQ has no effect.
- Assert `reset` during WAIT of word 1:
  - All strobes drop immediately and `checksum`=0.
  - After release, the copy restarts at `flash_addr`=`SRC_BASE`.
- `DST_BASE`=0xFFFFFFF8, `WORDS`=4: `pm_addr` wraps 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
